// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner/debouncer/encoder; optional auto-repeat under KEYPAD_REPEAT_EN.
// Press-to-strobe latency <= 2 + 3*SCAN_DIV + DEBOUNCE_CNT + 2 clocks; no backpressure, Valid_1 is a fire-and-forget strobe.
module keypad_scanner #(
  parameter int SCAN_DIV      = 16,
  parameter int DEBOUNCE_CNT  = 1024,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] Code_1,
  output logic       Valid_1,
  output logic       S_Row
);

  localparam int MAX_SD = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int MAX_RP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MAXP   = (MAX_SD > MAX_RP) ? MAX_SD : MAX_RP;
  localparam int CW     = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LIM   = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, HOLD, RELEASE} state_t;

  state_t        state, state_n;
  logic [3:0]    row_meta, rs;
  logic [1:0]    col_idx, col_idx_n, col_adv;
  logic [1:0]    row_idx, row_idx_n, low_idx;
  logic [CW-1:0] div_cnt, div_cnt_n, cnt, cnt_n;
  logic [3:0]    code_n, low, pat;
  logic          valid_n, srow_n, one_low;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] RD_LIM = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP_LIM = CW'(REPEAT_PERIOD);
  logic [CW-1:0] hold_cnt, hold_cnt_n;
  logic          rpt_first, rpt_first_n;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    sat_inc = (&x) ? x : x + ONE;
  endfunction

  function automatic logic [3:0] map_code(input logic [1:0] r, input logic [1:0] c);
    if (r == 2'd3) begin
      case (c)
        2'd0:    map_code = 4'b1011;
        2'd1:    map_code = 4'b0000;
        default: map_code = 4'b1010;
      endcase
    end else begin
      map_code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
  endfunction

  // Exactly one row low means a single candidate key; anything else is idle or a ghost.
  assign low     = ~rs;
  assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign low_idx = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
  assign pat     = ~(4'b0001 << row_idx);
  assign col_adv = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
      state    <= SCAN;
      col_idx  <= 2'd0;
      row_idx  <= 2'd0;
      div_cnt  <= '0;
      cnt      <= '0;
      Code_1   <= 4'h0;
      Valid_1  <= 1'b0;
      S_Row    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt  <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      row_meta <= row;
      rs       <= row_meta;
      state    <= state_n;
      col_idx  <= col_idx_n;
      row_idx  <= row_idx_n;
      div_cnt  <= div_cnt_n;
      cnt      <= cnt_n;
      Code_1   <= code_n;
      Valid_1  <= valid_n;
      S_Row    <= srow_n;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt  <= hold_cnt_n;
      rpt_first <= rpt_first_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    row_idx_n = row_idx;
    div_cnt_n = div_cnt;
    cnt_n     = cnt;
    code_n    = Code_1;
    valid_n   = 1'b0;
    srow_n    = S_Row;
`ifdef KEYPAD_REPEAT_EN
    hold_cnt_n  = hold_cnt;
    rpt_first_n = rpt_first;
`endif
    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (one_low) begin
            row_idx_n = low_idx;
            cnt_n     = ONE;
            state_n   = DEBOUNCE;
          end else begin
            col_idx_n = col_adv;
          end
        end else begin
          div_cnt_n = sat_inc(div_cnt);
        end
      end
      DEBOUNCE: begin
        if (rs != pat) begin
          state_n   = SCAN;
          col_idx_n = col_adv;
          cnt_n     = '0;
        end else begin
          cnt_n = sat_inc(cnt);
          if (cnt_n >= DB_LIM) begin
            state_n = EMIT;
            code_n  = map_code(row_idx, col_idx);
          end
        end
      end
      EMIT: begin
        valid_n = 1'b1;
        srow_n  = 1'b1;
        cnt_n   = '0;
        state_n = HOLD;
      end
      HOLD: begin
        if (rs[row_idx]) begin
          state_n = RELEASE;
          cnt_n   = ONE;
`ifdef KEYPAD_REPEAT_EN
          hold_cnt_n  = '0;
          rpt_first_n = 1'b1;
`endif
        end else begin
          cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
          hold_cnt_n = sat_inc(hold_cnt);
          if (hold_cnt_n == (rpt_first ? RD_LIM : RP_LIM)) begin
            valid_n     = 1'b1;
            hold_cnt_n  = '0;
            rpt_first_n = 1'b0;
          end
`endif
        end
      end
      RELEASE: begin
        if (!rs[row_idx]) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = sat_inc(cnt);
          if (cnt_n >= DB_LIM) begin
            state_n   = SCAN;
            srow_n    = 1'b0;
            col_idx_n = col_adv;
            div_cnt_n = '0;
            cnt_n     = '0;
          end
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_comb begin
    case (col_idx)
      2'd0:    col = 3'b110;
      2'd1:    col = 3'b101;
      default: col = 3'b011;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives row from col, a monitor logs Valid_1 pulses.
// Expected codes/latencies/pulse counts come from the key map and timing rules, not from the RTL.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RD = 50;
  localparam int RP = 20;
  localparam int LAT_MIN = DB + 2;
  localparam int LAT_MAX = 2 + 3 * SD + DB + 2 + 2;

  logic        clk = 1'b0;
  logic        reset_1 = 1'b0;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  Code_1;
  logic        Valid_1;
  logic        S_Row;
  logic [11:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         pt[$];
  logic [3:0] pc[$];
  bit         pstable[$];
  bit         prise[$];
  logic [3:0] code_d;
  logic       srow_d;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_1(reset_1), .row(row), .col(col),
    .Code_1(Code_1), .Valid_1(Valid_1), .S_Row(S_Row)
  );

  // A pressed key (index r*3+c) pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (Valid_1 === 1'b1) begin
        pt.push_back(cyc);
        pc.push_back(Code_1);
        pstable.push_back(Code_1 === code_d);
        prise.push_back(S_Row === 1'b1 && srow_d === 1'b0);
      end
      code_d = Code_1;
      srow_d = S_Row;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_code(input int k);
    case (k)
      9:       exp_code = 4'b1011;
      10:      exp_code = 4'b0000;
      11:      exp_code = 4'b1010;
      default: exp_code = 4'(k + 1);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic clear_log();
    pt.delete(); pc.delete(); pstable.delete(); prise.delete();
  endtask

  // Returns clocks from now until S_Row is low, or -1 if it never falls within the budget.
  task automatic wait_srow_low(output int fall);
    fall = -1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (S_Row === 1'b0) begin
        fall = i;
        break;
      end
    end
  endtask

  task automatic do_press(input int k, input int hold_clks, input int glitch, input string tag);
    int tp, fall;
    clear_log();
    if (glitch > 0) begin
      keys[k] = 1'b1;
      tick(glitch);
      keys[k] = 1'b0;
      tick(DB + 6);
      chk({tag, "_glitch_pulses"}, pt.size(), 0);
    end
    keys[k] = 1'b1;
    tp = cyc;
    tick(hold_clks);
    chk({tag, "_srow_held"}, S_Row, 1'b1);
    keys[k] = 1'b0;
    wait_srow_low(fall);
    chk_rng({tag, "_srow_fall"}, fall, DB, DB + 4);
    tick(4);
`ifdef KEYPAD_REPEAT_EN
    chk_rng({tag, "_pulses"}, pt.size(), 1, 1000);
`else
    chk({tag, "_pulses"}, pt.size(), 1);
`endif
    if (pt.size() > 0) begin
      chk({tag, "_code"}, pc[0], exp_code(k));
      chk({tag, "_code_stable"}, pstable[0], 1'b1);
      chk({tag, "_srow_rise"}, prise[0], 1'b1);
      chk_rng({tag, "_latency"}, pt[0] - tp, LAT_MIN, LAT_MAX);
    end
    chk({tag, "_code_kept"}, Code_1, exp_code(k));
  endtask

  initial begin
    logic [2:0] exp_col;
    logic [2:0] prev_col;
    int changes, fall, k;

    // Reset state
    tick(3);
    chk("rst_col", col, 3'b110);
    chk("rst_code", Code_1, 4'h0);
    chk("rst_valid", Valid_1, 1'b0);
    chk("rst_srow", S_Row, 1'b0);

    // Idle column rotation: index advances every SD clocks
    reset_1 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      exp_col = ~(3'b001 << ((n / SD) % 3));
      chk($sformatf("scan_col_%0d", n), col, exp_col);
    end
    tick(5);

    do_press(1, 100, 0, "key2");
    tick(10);
    do_press(11, $urandom_range(40, 80), 0, "key_hash");
    tick(7);
    do_press(9, $urandom_range(40, 80), 0, "key_star");
    tick(5);
    do_press(4, 60, 5, "key5_glitch");

    for (int i = 0; i < 6; i++) begin
      tick($urandom_range(3, 20));
      k = $urandom_range(0, 11);
      do_press(k, $urandom_range(40, 90), $urandom_range(0, 5), $sformatf("rnd%0d_k%0d", i, k));
    end

    tick(6);
    do_press(7, 50, 0, "key8");

    // Ghost: keys '1' and '7' share column 0, two rows low together
    clear_log();
    keys[0] = 1'b1;
    keys[6] = 1'b1;
    changes = 0;
    prev_col = col;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (col !== prev_col) changes++;
      prev_col = col;
    end
    keys = '0;
    chk("ghost_pulses", pt.size(), 0);
    chk_rng("ghost_col_changes", changes, 13, 16);
    chk("ghost_srow", S_Row, 1'b0);
    chk("ghost_code_kept", Code_1, 4'h8);
    tick(10);

    // Reset asserted while a press is being debounced
    reset_1 = 1'b0;
    tick(2);
    clear_log();
    reset_1 = 1'b1;
    keys[0] = 1'b1;
    tick(7);
    chk("deb_col_frozen", col, 3'b110);
    chk("deb_srow", S_Row, 1'b0);
    reset_1 = 1'b0;
    tick(1);
    chk("deb_rst_code", Code_1, 4'h0);
    chk("deb_rst_col", col, 3'b110);
    chk("deb_rst_srow", S_Row, 1'b0);
    chk("deb_rst_valid", Valid_1, 1'b0);
    keys = '0;
    tick(3);
    reset_1 = 1'b1;
    tick(30);
    chk("deb_rst_pulses", pt.size(), 0);

    k = $urandom_range(0, 11);
    do_press(k, 50, 0, $sformatf("recover_k%0d", k));

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: hold '9' for 120 clocks past the first strobe
    tick(8);
    clear_log();
    keys[8] = 1'b1;
    for (int i = 0; i < LAT_MAX + 5; i++) begin
      if (pt.size() > 0) break;
      tick(1);
    end
    chk_rng("rpt_first_seen", pt.size(), 1, 1);
    tick(120);
    keys[8] = 1'b0;
    wait_srow_low(fall);
    chk_rng("rpt_srow_fall", fall, DB, DB + 4);
    chk("rpt_pulses", pt.size(), 5);
    if (pt.size() == 5) begin
      chk_rng("rpt_gap0", pt[1] - pt[0], RD - 1, RD + 1);
      for (int i = 2; i < 5; i++)
        chk_rng($sformatf("rpt_gap%0d", i - 1), pt[i] - pt[i-1], RP - 1, RP + 1);
      for (int i = 0; i < 5; i++)
        chk($sformatf("rpt_code%0d", i), pc[i], 4'h9);
    end
    chk("rpt_code_kept", Code_1, 4'h9);
`endif

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
